crc_frame_serializer: RTL and testbench
=======================================

# crc_frame_serializer

Downstream stage of the sequential CRC generator in the FEC transmit path. Accepts one data word per frame and hands it to the CRC generator through a start/done interface. Latches the returned CRC, then serializes the frame MSB-first onto a per-bit valid/ready link: optional sync word, then data, then CRC. Watchdogs the generator and drops the frame if its CRC never arrives.

## Interface
Parameters:
- DATA_WIDTH, 12: payload width; must match the CRC generator.
- CRC_WIDTH, 4: CRC width; must match the CRC generator.
- SYNC_WIDTH, 8: sync word width. Used only with CRC_FRAME_SYNC_EN.
- SYNC_WORD, 8'hA5: sync pattern, sent MSB-first.
- TIMEOUT_CYCLES, 64: maximum cycles in S_CRC_WAIT before the frame is dropped; must be ≥ DATA_WIDTH+4.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_WIDTH  payload word.
- crc_start  out  1  one-cycle start pulse to the CRC generator.
- crc_data  out  DATA_WIDTH  payload to the CRC generator; held stable from the start pulse until the frame ends.
- crc_done  in  1  generator done (level; may stay high between frames).
- crc_value  in  CRC_WIDTH  generator CRC result; sampled on the qualified done edge.
- tx_bit  out  1  current serial bit.
- tx_valid  out  1  tx_bit valid.
- tx_ready  in  1  downstream accepts tx_bit.
- tx_sof  out  1  high with the first bit of the frame.
- tx_eof  out  1  high with the last bit of the frame.
- busy  out  1  frame in progress (state ≠ S_IDLE).
- err_timeout  out  1  one-cycle pulse when a frame is dropped.

## Operation
- Frame length FRAME_LEN = SYNC_WIDTH+DATA_WIDTH+CRC_WIDTH with the sync word, DATA_WIDTH+CRC_WIDTH without.
- States: S_IDLE, S_CRC_REQ, S_CRC_WAIT, S_SEND.
- S_IDLE:
  - in_ready = 1.
  - On in_valid: latch in_data into crc_data and go to S_CRC_REQ.
- S_CRC_REQ:
  - crc_start = 1 for exactly one cycle.
  - Clear the watchdog counter and go to S_CRC_WAIT.
- S_CRC_WAIT:
  - Track a registered copy of crc_done. Accept completion only on a rising edge (crc_done=1 and the previous sample = 0), because a stale done from the previous frame can still be high.
  - On the edge: load the shift register with {SYNC_WORD, crc_data, crc_value} (or {crc_data, crc_value} without the sync word), load bit_cnt = FRAME_LEN-1, and go to S_SEND.
  - If the watchdog reaches TIMEOUT_CYCLES-1 with no edge: pulse err_timeout, discard the frame, and return to S_IDLE.
- S_SEND:
  - tx_valid = 1 and tx_bit = MSB of the shift register.
  - tx_sof = 1 only while bit_cnt = FRAME_LEN-1; tx_eof = 1 only while bit_cnt = 0.
  - On tx_valid&&tx_ready: shift left by one and decrement bit_cnt.
  - On the handshake at bit_cnt = 0: go to S_IDLE.
  - tx_bit, tx_sof and tx_eof hold while tx_ready = 0.
- An edge on crc_done outside S_CRC_WAIT is ignored. The done-edge register still updates every cycle.
- bit_cnt width is $clog2(FRAME_LEN). The watchdog width is $clog2(TIMEOUT_CYCLES). Neither may wrap.

## Timing
- Reset values:
  - state = S_IDLE.
  - in_ready = 0 while rst is high, 1 in the first cycle after release.
  - crc_start, tx_valid, tx_bit, tx_sof, tx_eof, busy, err_timeout = 0.
  - crc_data = 0; done-edge register = 0.
- Reset mid-frame aborts at once: no tx_eof is emitted and no err_timeout pulse.
- Word accepted at cycle T → crc_start high in T+1 → crc_done edge seen at cycle D → tx_valid and tx_sof high in D+1.
- With tx_ready held high, the frame occupies cycles D+1 … D+FRAME_LEN, and in_ready returns in D+FRAME_LEN+1.
- Throughput is one bit per cycle. A new word is never accepted while busy.
- tx_sof and tx_eof are never high in the same cycle (FRAME_LEN ≥ 2).

## Configuration
- CRC_FRAME_SYNC_EN defined: SYNC_WORD is prepended and FRAME_LEN includes SYNC_WIDTH.
- Not defined: the frame is data followed by CRC only. SYNC_WIDTH and SYNC_WORD are ignored, and tx_sof marks the data MSB.

## Structure
- Package crc_frame_pkg holds:
  - state_t (logic [1:0]) with S_IDLE, S_CRC_REQ, S_CRC_WAIT, S_SEND;
  - a frame_len(data_w, crc_w, sync_w) function;
  - the default SYNC_WORD constant.
- One sub-module, crc_frame_shifter:
  - inputs: load, load_value, shift enable;
  - outputs: MSB, first/last flags;
  - owns the shift register and bit_cnt.
- The top level owns the FSM, the done-edge detect and the watchdog.

## Test plan
Use a stub CRC generator that raises done N cycles after start.
- Basic frame: sync enabled, in_data=12'hABC, stub returns 4'h7 after 13 cycles, tx_ready=1 → 24 bits 0xA5, 0xABC, 0x7 MSB-first; sof on bit 0, eof on bit 23; in_ready back the cycle after eof.
- Backpressure: tx_ready toggled 1,0,0,1 repeatedly → no bit lost or duplicated; tx_bit, tx_sof and tx_eof stable while stalled; same 24-bit sequence.
- Stale done: stub holds crc_done=1 from the previous frame until 1 cycle after start, then re-asserts 13 cycles later → CRC taken only from the new rising edge.
- Timeout: stub never asserts done → err_timeout pulses exactly 64 cycles after crc_start; no tx_valid; in_ready=1 the next cycle.
- Reset mid-SEND: assert rst at bit 10 → all outputs 0 the next cycle; no eof; the next word (12'h123) frames correctly.
- Sync disabled: in_data=12'h000, CRC 4'h0 → 16 zero bits, sof on the first bit, eof on bit 15.

Source files
------------

// File: rtl/crc_frame_pkg.sv
// Shared types and helpers for the CRC frame serializer.
package crc_frame_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CRC_REQ  = 2'd1,
        S_CRC_WAIT = 2'd2,
        S_SEND     = 2'd3
    } state_t;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

    function automatic int unsigned frame_len(input int unsigned data_w,
                                              input int unsigned crc_w,
                                              input int unsigned sync_w);
        return data_w + crc_w + sync_w;
    endfunction

endpackage

// File: rtl/crc_frame_shifter.sv
// MSB-first frame shift register with bit counter and first/last-bit flags.
module crc_frame_shifter
    import crc_frame_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [FRAME_LEN-1:0] load_value_i,
    input  logic                 shift_i,
    output logic                 msb_o,
    output logic                 first_o,
    output logic                 last_o
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN);

    logic [FRAME_LEN-1:0] sreg_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 first_q;
    logic                 last_q;

    // Flags are kept as flops so they track the counter without extra decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            sreg_q  <= load_value_i;
            cnt_q   <= CNT_W'(FRAME_LEN - 1);
            first_q <= 1'b1;
            last_q  <= 1'b0;
        end else if (shift_i) begin
            sreg_q  <= {sreg_q[FRAME_LEN-2:0], 1'b0};
            first_q <= 1'b0;
            last_q  <= (cnt_q == CNT_W'(1));
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign msb_o   = sreg_q[FRAME_LEN-1];
    assign first_o = first_q;
    assign last_o  = last_q;

endmodule

// File: rtl/crc_frame_serializer.sv
// Hands a word to the CRC generator, then serializes {sync, data, crc} MSB-first.
// The sync word prefix is enabled by defining CRC_FRAME_SYNC_EN.
module crc_frame_serializer
    import crc_frame_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH     = 12,
    parameter int unsigned            CRC_WIDTH      = 4,
    parameter int unsigned            SYNC_WIDTH     = 8,
    parameter logic [SYNC_WIDTH-1:0]  SYNC_WORD      = SYNC_WIDTH'(SYNC_WORD_DEFAULT),
    parameter int unsigned            TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  crc_start,
    output logic [DATA_WIDTH-1:0] crc_data,
    input  logic                  crc_done,
    input  logic [CRC_WIDTH-1:0]  crc_value,
    output logic                  tx_bit,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_sof,
    output logic                  tx_eof,
    output logic                  busy,
    output logic                  err_timeout
);

`ifdef CRC_FRAME_SYNC_EN
    localparam int unsigned FRAME_LEN = frame_len(DATA_WIDTH, CRC_WIDTH, SYNC_WIDTH);
`else
    localparam int unsigned FRAME_LEN = frame_len(DATA_WIDTH, CRC_WIDTH, 0);
`endif
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] crc_data_q, crc_data_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;
    logic                  done_q;
    logic                  in_ready_q;
    logic                  crc_start_q;
    logic                  tx_valid_q;
    logic                  busy_q;

    logic                  done_rise_c;
    logic                  load_c;
    logic                  shift_c;
    logic                  timeout_c;
    logic [FRAME_LEN-1:0]  load_value;
    logic                  sh_msb, sh_first, sh_last;

    // Without the sync word the truncating cast drops the SYNC_WORD bits.
    assign load_value  = FRAME_LEN'({SYNC_WORD, crc_data_q, crc_value});
    assign done_rise_c = crc_done & ~done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            crc_data_q  <= '0;
            wdog_q      <= '0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            crc_start_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_data_q  <= crc_data_d;
            wdog_q      <= wdog_d;
            done_q      <= crc_done;
            in_ready_q  <= (state_d == S_IDLE);
            crc_start_q <= (state_d == S_CRC_REQ);
            tx_valid_q  <= (state_d == S_SEND);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        state_d    = state_q;
        crc_data_d = crc_data_q;
        wdog_d     = wdog_q;
        load_c     = 1'b0;
        shift_c    = 1'b0;
        timeout_c  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    crc_data_d = in_data;
                    state_d    = S_CRC_REQ;
                end
            end
            S_CRC_REQ: begin
                wdog_d  = '0;
                state_d = S_CRC_WAIT;
            end
            S_CRC_WAIT: begin
                // A done edge in the final watchdog cycle still wins.
                if (done_rise_c) begin
                    load_c  = 1'b1;
                    state_d = S_SEND;
                end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_c = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            S_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    shift_c = 1'b1;
                    if (sh_last) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    crc_frame_shifter #(
        .FRAME_LEN (FRAME_LEN)
    ) u_shifter (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load_c),
        .load_value_i (load_value),
        .shift_i      (shift_c),
        .msb_o        (sh_msb),
        .first_o      (sh_first),
        .last_o       (sh_last)
    );

    assign in_ready    = in_ready_q;
    assign crc_start   = crc_start_q;
    assign crc_data    = crc_data_q;
    assign tx_bit      = sh_msb;
    assign tx_valid    = tx_valid_q;
    assign tx_sof      = sh_first;
    assign tx_eof      = sh_last;
    assign busy        = busy_q;
    assign err_timeout = timeout_c & ~rst;

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Directed bench for crc_frame_serializer with a stub CRC generator and bit scoreboard.
module tb_crc_frame_serializer;

`ifdef CRC_FRAME_SYNC_EN
    localparam int FL = 24;
`else
    localparam int FL = 16;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_data = 12'h000;
    logic        crc_start;
    logic [11:0] crc_data;
    logic        crc_done = 1'b0;
    logic [3:0]  crc_value = 4'h0;
    logic        tx_bit, tx_valid, tx_sof, tx_eof, busy, err_timeout;
    logic        tx_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [2:0] exp_q[$];
    int  bits_done = 0;
    int  eof_cnt = 0;
    int  err_cnt = 0;
    bit  prev_stall = 1'b0;
    logic [2:0] prev_flags = 3'b000;

    int         stub_delay = 13;
    bit         stub_never = 1'b0;
    logic [3:0] stub_value = 4'h0;
    bit         stub_armed = 1'b0;
    int         stub_cnt = 0;
    int         start_cyc = 0;
    int         raise_cyc = 0;

    crc_frame_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .crc_start   (crc_start),
        .crc_data    (crc_data),
        .crc_done    (crc_done),
        .crc_value   (crc_value),
        .tx_bit      (tx_bit),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_sof      (tx_sof),
        .tx_eof      (tx_eof),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stub generator: keeps a stale done high until 2 cycles after start, raises it stub_delay cycles after start.
    always begin
        @(posedge clk);
        #2;
        if (rst) begin
            crc_done   = 1'b0;
            stub_armed = 1'b0;
        end else if (crc_start) begin
            stub_armed = 1'b1;
            stub_cnt   = 0;
            start_cyc  = cyc;
        end else if (stub_armed) begin
            stub_cnt++;
            if (stub_cnt == 2) crc_done = 1'b0;
            if (!stub_never && stub_cnt == stub_delay) begin
                crc_done   = 1'b1;
                crc_value  = stub_value;
                raise_cyc  = cyc;
                stub_armed = 1'b0;
            end
        end
    end

    // Output monitor: pops expected bits on handshakes and checks stall stability.
    always @(negedge clk) begin
        logic [2:0] e;
        if (err_timeout) err_cnt++;
        if (!rst && tx_valid) begin
            if (prev_stall) check("stall_hold", 32'({tx_bit, tx_sof, tx_eof}), 32'(prev_flags));
            if (tx_sof) check("sof_eof_excl", 32'(tx_eof), 32'(0));
            if (tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", 32'(exp_q.size()), 32'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("bit_sof_eof", 32'({tx_bit, tx_sof, tx_eof}), 32'(e));
                end
                bits_done++;
                if (tx_eof) eof_cnt++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                prev_flags = {tx_bit, tx_sof, tx_eof};
            end
        end else begin
            if (prev_stall && !rst) check("stall_valid_drop", 32'(tx_valid), 32'(1));
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [11:0] d, input logic [3:0] c);
        logic [FL-1:0] w;
`ifdef CRC_FRAME_SYNC_EN
        w = {8'hA5, d, c};
`else
        w = {d, c};
`endif
        for (int i = FL - 1; i >= 0; i--) exp_q.push_back({w[i], i == FL - 1, i == 0});
    endtask

    task automatic send_word(input logic [11:0] d, input logic [3:0] c, input int dly, input bit never);
        int b;
        stub_value = c;
        stub_delay = dly;
        stub_never = never;
        b = 0;
        while (!in_ready && b < 50) begin step(); b++; end
        check("in_ready_wait", 32'(in_ready), 32'(1));
        in_valid = 1'b1;
        in_data  = d;
        if (!never) push_frame(d, c);
        step();
        in_valid = 1'b0;
        check("start_busy_ready", 32'({crc_start, busy, in_ready}), 32'(3'b110));
        check("crc_data", 32'(crc_data), 32'(d));
        step();
        check("start_pulse_end", 32'(crc_start), 32'(0));
    endtask

    function automatic bit ready_pat(input int i);
        return (i % 4 == 0) || (i % 4 == 3);
    endfunction

    task automatic run_frame(input bit bp, input int exp_eofs);
        int b;
        int i;
        b = 0;
        while (!tx_valid && b < 100) begin step(); b++; end
        check("sof_latency", 32'(cyc), 32'(raise_cyc + 1));
        check("first_sof", 32'({tx_valid, tx_sof}), 32'(2'b11));
        tx_ready = bp ? ready_pat(0) : 1'b1;
        i = 1;
        b = 0;
        while (exp_q.size() != 0 && b < 400) begin
            step();
            tx_ready = bp ? ready_pat(i) : 1'b1;
            i++;
            b++;
        end
        tx_ready = 1'b1;
        check("frame_complete", 32'(exp_q.size()), 32'(0));
        check("ready_after_eof", 32'({in_ready, busy, tx_valid}), 32'(3'b100));
        check("eof_count", 32'(eof_cnt), 32'(exp_eofs));
    endtask

    initial begin
        int b;
        int target;
        bit saw_valid;

        step();
        step();
        check("reset_outs", 32'({in_ready, crc_start, tx_valid, tx_bit, tx_sof, tx_eof, busy, err_timeout}), 32'(0));
        check("reset_crc_data", 32'(crc_data), 32'(0));
        rst = 1'b0;
        step();
        check("ready_after_release", 32'({in_ready, busy}), 32'(2'b10));

        // Basic frame
        send_word(12'hABC, 4'h7, 13, 1'b0);
        run_frame(1'b0, 1);
        // Backpressure with stale done from the previous frame
        send_word(12'h3C6, 4'hB, 13, 1'b0);
        run_frame(1'b1, 2);
        // Stale done with a short gap before the new edge
        send_word(12'h5E1, 4'h2, 3, 1'b0);
        run_frame(1'b0, 3);
        check("no_err_yet", 32'(err_cnt), 32'(0));

        // Timeout: generator never answers
        send_word(12'hFFF, 4'h0, 0, 1'b1);
        b = 0;
        saw_valid = 1'b0;
        while (!err_timeout && b < 100) begin
            step();
            if (tx_valid) saw_valid = 1'b1;
            b++;
        end
        check("timeout_cycle", 32'(cyc - start_cyc), 32'(64));
        check("timeout_no_valid", 32'(saw_valid), 32'(0));
        step();
        check("after_timeout", 32'({err_timeout, in_ready, busy}), 32'(3'b010));
        check("err_pulse_count", 32'(err_cnt), 32'(1));

        // Reset in the middle of the send phase at bit 10
        send_word(12'h5A5, 4'hC, 13, 1'b0);
        target = bits_done + 10;
        b = 0;
        while (bits_done < target && b < 200) begin step(); b++; end
        rst = 1'b1;
        tx_ready = 1'b0;
        step();
        check("midframe_reset_outs", 32'({in_ready, crc_start, tx_valid, tx_bit, tx_sof, tx_eof, busy, err_timeout}), 32'(0));
        exp_q.delete();
        rst = 1'b0;
        tx_ready = 1'b1;
        step();
        check("no_eof_on_reset", 32'(eof_cnt), 32'(3));
        check("no_err_on_reset", 32'(err_cnt), 32'(1));
        send_word(12'h123, 4'h9, 13, 1'b0);
        run_frame(1'b0, 4);

        // All-zero frame
        send_word(12'h000, 4'h0, 13, 1'b0);
        run_frame(1'b1, 5);
        check("final_err_count", 32'(err_cnt), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
